// File: rtl/accelbrot_com_pkg.sv
// rtl/accelbrot_com_pkg.sv - shared types and helpers for the accelbrot sign operator
package accelbrot_com_pkg;

  localparam int SM_W = 2;

  typedef enum logic [SM_W-1:0] {
    SM_PASS = 2'd0,
    SM_NEG  = 2'd1,
    SM_ABS  = 2'd2,
    SM_CSGN = 2'd3
  } sign_mode_t;

  // Whether a lane negates its whole number, given its mode, the external
  // negate request and the sign taken from the number's last word.
  function automatic logic negate_decision(sign_mode_t mode, logic ext_neg, logic sign);
    logic dec;
    dec = 1'b0;
    case (mode)
      SM_PASS: dec = 1'b0;
      SM_NEG:  dec = 1'b1;
      SM_ABS:  dec = sign;
      SM_CSGN: dec = ext_neg;
      default: dec = 1'b0;
    endcase
    return dec;
  endfunction

endpackage

// File: rtl/accelbrot_com_signop_if.sv
// rtl/accelbrot_com_signop_if.sv - word-serial input/output bundle of the sign operator
interface accelbrot_com_signop_if #(
  parameter int NCH    = 2,
  parameter int WWIDTH = 34
);

  logic [NCH*WWIDTH-1:0]                  in_data;
  logic [NCH*accelbrot_com_pkg::SM_W-1:0] in_mode;
  logic [NCH-1:0]                         in_neg;
  logic                                   in_start;
  logic                                   in_valid;

  logic [NCH*WWIDTH-1:0]                  out_data;
  logic [NCH-1:0]                         out_sign;
  logic [NCH-1:0]                         out_ovf;
  logic                                   out_start;
  logic                                   out_valid;
  logic                                   out_last;

  modport master (
    output in_data, in_mode, in_neg, in_start, in_valid,
    input  out_data, out_sign, out_ovf, out_start, out_valid, out_last
  );

  modport slave (
    input  in_data, in_mode, in_neg, in_start, in_valid,
    output out_data, out_sign, out_ovf, out_start, out_valid, out_last
  );

endinterface

// File: rtl/accelbrot_com_delay.sv
// rtl/accelbrot_com_delay.sv - resettable fixed-depth shift-register delay line
module accelbrot_com_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/accelbrot_com_negser.sv
// rtl/accelbrot_com_negser.sv - one lane of word-serial conditional two's-complement negation
module accelbrot_com_negser
  import accelbrot_com_pkg::*;
#(
  parameter int WWIDTH = 34
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              v_i,
  input  logic              start_i,
  input  logic [WWIDTH-1:0] data_i,
  input  sign_mode_t        mode_i,
  input  logic              neg_i,
  input  logic              last_msb_i,
  input  logic              last_i,
  output logic [WWIDTH-1:0] data_o,
  output logic              sign_o,
  output logic              ovf_o
);

  logic [WWIDTH-1:0] data_q, data_d;
  logic              carry_q, carry_d;
  logic              sign_q, sign_d;
  logic              neg_q, neg_d;
  logic              cin;
  logic [WWIDTH:0]   sum;

  // The decision and sign are taken on the start word and then held, so mode
  // or neg changes inside a number have no effect.
  always_comb begin
    sign_d  = sign_q;
    neg_d   = neg_q;
    cin     = carry_q;
    if (start_i) begin
      sign_d = last_msb_i;
      neg_d  = negate_decision(mode_i, neg_i, last_msb_i);
      cin    = 1'b1;
    end
    sum     = {1'b0, ~data_i} + {{WWIDTH{1'b0}}, cin};
    carry_d = sum[WWIDTH];
    data_d  = neg_d ? sum[WWIDTH-1:0] : data_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      carry_q <= 1'b0;
      sign_q  <= 1'b0;
      neg_q   <= 1'b0;
    end else if (v_i) begin
      data_q  <= data_d;
      carry_q <= carry_d;
      sign_q  <= sign_d;
      neg_q   <= neg_d;
    end
  end

  assign data_o = data_q;
  assign sign_o = sign_q;
  // Negating the most negative value yields itself: sign stays 1.
  assign ovf_o  = last_i & neg_q & sign_q & data_q[WWIDTH-1];

endmodule

// File: rtl/accelbrot_com_signop.sv
// rtl/accelbrot_com_signop.sv - multi-lane mode-selectable sign operator for word-serial numbers
module accelbrot_com_signop
  import accelbrot_com_pkg::*;
#(
  parameter int NWORDS = 8,
  parameter int WWIDTH = 34,
  parameter int NCH    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  accelbrot_com_signop_if.slave bus
);

  localparam int DW = 2 + NCH*WWIDTH + NCH*SM_W + NCH;
  localparam int CW = $clog2(NWORDS);

  logic [DW-1:0]          dl_in, dl_out;
  logic                   d_valid, d_start;
  logic [NCH*WWIDTH-1:0]  d_data;
  logic [NCH*SM_W-1:0]    d_mode;
  logic [NCH-1:0]         d_neg;

  logic                   out_valid_q, out_valid_d;
  logic                   out_start_q, out_start_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   out_last;
  logic                   accept;

  logic [WWIDTH-1:0]      lane_data [NCH];
  logic [NCH-1:0]         lane_sign, lane_ovf;

  // Delay by NWORDS-1 so the start word meets the last word on in_data.
  assign dl_in = {bus.in_valid, bus.in_start, bus.in_data, bus.in_mode, bus.in_neg};

  accelbrot_com_delay #(
    .WIDTH (DW),
    .DEPTH (NWORDS-1)
  ) u_delay (
    .clk (clk),
    .rst (rst),
    .d_i (dl_in),
    .q_o (dl_out)
  );

  assign {d_valid, d_start, d_data, d_mode, d_neg} = dl_out;

  assign out_last = out_valid_q & ~out_start_q & (cnt_q == CW'(NWORDS-1));

  // A continuation word is only taken directly behind an unfinished number;
  // orphans (e.g. the tail of a number cut by reset) are dropped.
  assign accept = d_valid & (d_start | (out_valid_q & ~out_last));

  always_comb begin
    out_valid_d = accept;
    out_start_d = accept & d_start;
    cnt_d       = cnt_q;
    if (out_valid_q) begin
      if (out_start_q) begin
        cnt_d = CW'(1);
      end else if (out_last) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_start_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_start_q <= out_start_d;
      cnt_q       <= cnt_d;
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_lane
    accelbrot_com_negser #(
      .WWIDTH (WWIDTH)
    ) u_negser (
      .clk        (clk),
      .rst        (rst),
      .v_i        (accept),
      .start_i    (d_start),
      .data_i     (d_data[k*WWIDTH +: WWIDTH]),
      .mode_i     (sign_mode_t'(d_mode[k*SM_W +: SM_W])),
      .neg_i      (d_neg[k]),
      .last_msb_i (bus.in_data[k*WWIDTH + WWIDTH - 1]),
      .last_i     (out_last),
      .data_o     (lane_data[k]),
      .sign_o     (lane_sign[k]),
      .ovf_o      (lane_ovf[k])
    );
    assign bus.out_data[k*WWIDTH +: WWIDTH] = lane_data[k];
  end

  assign bus.out_sign  = lane_sign;
  assign bus.out_ovf   = lane_ovf;
  assign bus.out_start = out_start_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last;

endmodule

// File: tb/tb_accelbrot_com_signop.sv
// tb/tb_accelbrot_com_signop.sv - directed self-checking bench for accelbrot_com_signop
module tb_accelbrot_com_signop;
  import accelbrot_com_pkg::*;

  localparam int NW  = 3;
  localparam int W   = 8;
  localparam int NCH = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  accelbrot_com_signop_if #(.NCH(NCH), .WWIDTH(W)) bus ();

  accelbrot_com_signop #(
    .NWORDS (NW),
    .WWIDTH (W),
    .NCH    (NCH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_run  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    int          cyc;
    logic [15:0] data;
    logic [1:0]  sign;
    logic [1:0]  ovf;
    logic        start;
    logic        last;
  } rec_t;

  rec_t recs[$];

  always @(negedge clk) begin
    rec_t r;
    if (bus.out_valid === 1'b1) begin
      r.cyc   = cyc;
      r.data  = bus.out_data;
      r.sign  = bus.out_sign;
      r.ovf   = bus.out_ovf;
      r.start = bus.out_start;
      r.last  = bus.out_last;
      recs.push_back(r);
    end
  end

  int          st_cyc [5];
  logic [23:0] exp_v0 [5] = '{24'h000005, 24'h563412, 24'h800000, 24'hFFFFF9, 24'h000003};
  logic [23:0] exp_v1 [5] = '{24'h000100, 24'hFFFFFF, 24'hFFFFF9, 24'h800000, 24'h000000};
  logic [1:0]  exp_s  [5] = '{2'b11, 2'b00, 2'b01, 2'b11, 2'b00};
  logic [1:0]  exp_o  [5] = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b00};

  // Mode and neg are inverted on the non-start words; they must be ignored.
  task automatic send(input logic [23:0] v0, input logic [23:0] v1,
                      input sign_mode_t m0, input sign_mode_t m1,
                      input logic n0, input logic n1, input int slot);
    for (int w = 0; w < NW; w++) begin
      @(posedge clk);
      #1;
      if (w == 0) st_cyc[slot] = cyc;
      bus.in_valid = 1'b1;
      bus.in_start = (w == 0);
      bus.in_data  = {v1[8*w +: 8], v0[8*w +: 8]};
      bus.in_mode  = (w == 0) ? {m1, m0} : ~{m1, m0};
      bus.in_neg   = (w == 0) ? {n1, n0} : ~{n1, n0};
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.in_start = 1'b0;
    end
  endtask

  initial begin
    logic [23:0] got0, got1;
    int          base;
    rec_t        r;

    bus.in_data  = '0;
    bus.in_mode  = '0;
    bus.in_neg   = '0;
    bus.in_start = 1'b0;
    bus.in_valid = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_data",  32'(bus.out_data),  32'h0);
    chk("rst_sign",  32'(bus.out_sign),  32'h0);
    chk("rst_ovf",   32'(bus.out_ovf),   32'h0);
    chk("rst_start", 32'(bus.out_start), 32'h0);
    chk("rst_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_last",  32'(bus.out_last),  32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    send(24'hFFFFFB, 24'hFFFF00, SM_ABS,  SM_ABS,  1'b0, 1'b0, 0);
    send(24'h563412, 24'h000001, SM_PASS, SM_NEG,  1'b0, 1'b0, 1);
    send(24'h800000, 24'h000007, SM_ABS,  SM_CSGN, 1'b0, 1'b1, 2);
    idle(2);
    send(24'hFFFFF9, 24'h800000, SM_CSGN, SM_NEG,  1'b0, 1'b0, 3);
    idle(6);

    // Reset lands on the second word; the third word arrives as an orphan.
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.in_start = 1'b1;
    bus.in_data  = 16'hFBFB;
    bus.in_mode  = {SM_ABS, SM_ABS};
    @(posedge clk);
    #1;
    rst          = 1'b1;
    bus.in_start = 1'b0;
    bus.in_data  = 16'hFFFF;
    @(posedge clk);
    #1;
    rst          = 1'b0;
    bus.in_data  = 16'hFFFF;
    @(negedge clk);
    chk("midrst_data",  32'(bus.out_data),  32'h0);
    chk("midrst_sign",  32'(bus.out_sign),  32'h0);
    chk("midrst_ovf",   32'(bus.out_ovf),   32'h0);
    chk("midrst_start", 32'(bus.out_start), 32'h0);
    chk("midrst_valid", 32'(bus.out_valid), 32'h0);
    chk("midrst_last",  32'(bus.out_last),  32'h0);
    idle(2);

    send(24'h000003, 24'h000000, SM_ABS, SM_NEG, 1'b0, 1'b0, 4);
    idle(8);

    chk("record_count", 32'(recs.size()), 32'd15);
    if (recs.size() >= 4) begin
      chk("b2b_adjacent", 32'(recs[3].cyc - recs[2].cyc), 32'd1);
    end

    for (int s = 0; s < 5; s++) begin
      base = s * NW;
      if (recs.size() >= base + NW) begin
        got0 = '0;
        got1 = '0;
        for (int w = 0; w < NW; w++) begin
          r = recs[base + w];
          got0[8*w +: 8] = r.data[7:0];
          got1[8*w +: 8] = r.data[15:8];
          chk($sformatf("n%0d_w%0d_cycle", s, w), 32'(r.cyc), 32'(st_cyc[s] + NW + w));
          chk($sformatf("n%0d_w%0d_start", s, w), 32'(r.start), 32'(w == 0));
          chk($sformatf("n%0d_w%0d_last", s, w), 32'(r.last), 32'(w == NW - 1));
          chk($sformatf("n%0d_w%0d_sign", s, w), 32'(r.sign), 32'(exp_s[s]));
          chk($sformatf("n%0d_w%0d_ovf", s, w), 32'(r.ovf),
              (w == NW - 1) ? 32'(exp_o[s]) : 32'h0);
        end
        chk($sformatf("n%0d_lane0", s), 32'(got0), 32'(exp_v0[s]));
        chk($sformatf("n%0d_lane1", s), 32'(got1), 32'(exp_v1[s]));
      end else begin
        chk($sformatf("n%0d_present", s), 32'(recs.size()), 32'(base + NW));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
